hdlc_rx_deframer: RTL and testbench
===================================

HDLC_RX_DEFRAMER -- requirements
Module: hdlc_rx_deframer

Interface
REQ-001 The block SHALL have one clock, and reset SHALL be asynchronous and active-low.
REQ-002 Clk  in  1  sole clock; all flops SHALL update on the rising edge.
REQ-003 Rst  in  1  asynchronous active-low reset.
REQ-004 RxEN  in  1  receiver enable; low SHALL force the idle state synchronously.
REQ-005 Rx  in  1  serial line, one bit sampled per Clk, idle high.
REQ-006 Rx_FlagDetect  out  1  one-cycle pulse on a received flag (01111110).
REQ-007 Rx_AbortDetect  out  1  one-cycle pulse on a received abort (0 followed by 7 ones).
REQ-008 Rx_AbortSignal  out  1  one-cycle pulse on an abort received while Rx_ValidFrame is high.
REQ-009 Rx_ValidFrame  out  1  high while a frame is in progress.
REQ-010 Rx_Data  out  8  de-stuffed byte, first-received bit in bit 0; valid when Rx_WrBuff is high.
REQ-011 Rx_WrBuff  out  1  one-cycle write strobe for Rx_Data.
REQ-012 Rx_EoF  out  1  one-cycle end-of-frame pulse.
REQ-013 Rx_FrameError  out  1  one-cycle pulse, coincident with Rx_EoF, on a non-octet-aligned frame.

Function
REQ-014 Each cycle with RxEN high, Rx SHALL shift into an 8-bit window; window[7] is the newest bit.
REQ-015 Flag: when the window equals 0,1,1,1,1,1,1,0 (oldest to newest), Rx_FlagDetect SHALL pulse on the second rising edge after the edge that sampled the closing 0.
REQ-016 Abort: when a 0 is followed by 7 consecutive ones, Rx_AbortDetect SHALL rise on the second edge after the edge that sampled the 7th one; a longer run of ones SHALL NOT retrigger it.
REQ-017 The block SHALL implement the FSM IDLE -> HUNT -> FRAME.
REQ-018 FSM, IDLE: entered after reset or while RxEN is low; it SHALL go to HUNT when RxEN is high.
REQ-019 FSM, HUNT: it SHALL go to FRAME on a flag.
REQ-020 FSM, FRAME: a flag SHALL close the frame and keep the FSM in FRAME, so a shared flag also opens the next frame; an abort SHALL return the FSM to HUNT.
REQ-021 Rx_ValidFrame SHALL rise with the first Rx_WrBuff after an opening flag.
REQ-022 Rx_ValidFrame SHALL fall in the same cycle as the closing Rx_FlagDetect or the Rx_AbortDetect.
REQ-023 Back-to-back flags SHALL NOT raise Rx_ValidFrame.
REQ-024 Zero removal: inside FRAME, a 0 that follows exactly five consecutive ones SHALL be discarded and not counted as a data bit; a sixth one SHALL NOT be discarded.
REQ-025 Data bits SHALL be released to the byte assembler only after leaving the 8-bit window, so flag and abort bits are never emitted as data.
REQ-026 After every 8 released data bits, Rx_Data SHALL load and Rx_WrBuff SHALL pulse for one cycle; the bit counter SHALL wrap 7 -> 0.
REQ-027 Rx_EoF SHALL pulse on the cycle after each falling edge of Rx_ValidFrame, whether the frame ended on a flag or an abort.
REQ-028 Rx_FrameError SHALL pulse with Rx_EoF when a closing flag finds a residual bit count other than 0; the residual bits SHALL be dropped.
REQ-029 Rx_AbortSignal SHALL pulse the cycle after Rx_AbortDetect when Rx_ValidFrame was high in the Rx_AbortDetect cycle; it SHALL stay low otherwise.
REQ-030 Simultaneous events: an abort that completes in the same cycle as byte completion SHALL suppress Rx_WrBuff.
REQ-031 Dropping RxEN mid-frame SHALL clear Rx_ValidFrame without producing Rx_EoF, Rx_AbortSignal or Rx_WrBuff.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 While Rst is low, every output SHALL be 0, with Rx_Data = 8'h00.
REQ-034 While Rst is low, the window SHALL be all ones, the ones counter and bit counter SHALL be 0, and the FSM SHALL be in IDLE.
REQ-035 Reset asserted mid-frame SHALL clear all state immediately; no Rx_EoF SHALL follow its release.

Verification
REQ-036 Flag, idle ones, then 0x7E -> Rx_FlagDetect high exactly 2 edges after the closing 0 is sampled; Rx_ValidFrame stays 0.
REQ-037 Flag, bytes 0xA5 and 0x3C, flag -> two Rx_WrBuff pulses with Rx_Data 0xA5 then 0x3C; Rx_ValidFrame falls with Rx_FlagDetect; Rx_EoF the next cycle; Rx_FrameError 0.
REQ-038 Flag, byte 0xFF sent stuffed as 11111011 1 -> one Rx_WrBuff with Rx_Data 0xFF, and no flag or abort detected.
REQ-039 Flag, 0x12, then 0 and 7 ones -> Rx_AbortDetect 2 edges after the 7th one; Rx_AbortSignal the next cycle; Rx_EoF follows; the FSM returns to HUNT.
REQ-040 Flag, 0x12, 3 extra bits, flag -> Rx_EoF and Rx_FrameError pulse together; exactly one Rx_WrBuff (0x12).
REQ-041 Rst driven low mid-frame -> all outputs 0 asynchronously, and no Rx_EoF after release.

Source files
------------

// File: rtl/hdlc_rx_deframer_if.sv
// Receive-side bundle of the HDLC deframer: serial line in,
// deframed bytes and frame event strobes out.
interface hdlc_rx_deframer_if;
    logic       RxEN;
    logic       Rx;
    logic       Rx_FlagDetect;
    logic       Rx_AbortDetect;
    logic       Rx_AbortSignal;
    logic       Rx_ValidFrame;
    logic [7:0] Rx_Data;
    logic       Rx_WrBuff;
    logic       Rx_EoF;
    logic       Rx_FrameError;

    modport master (
        input  RxEN,
        input  Rx,
        output Rx_FlagDetect,
        output Rx_AbortDetect,
        output Rx_AbortSignal,
        output Rx_ValidFrame,
        output Rx_Data,
        output Rx_WrBuff,
        output Rx_EoF,
        output Rx_FrameError
    );

    modport slave (
        output RxEN,
        output Rx,
        input  Rx_FlagDetect,
        input  Rx_AbortDetect,
        input  Rx_AbortSignal,
        input  Rx_ValidFrame,
        input  Rx_Data,
        input  Rx_WrBuff,
        input  Rx_EoF,
        input  Rx_FrameError
    );
endinterface

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag/abort detection, zero removal,
// byte assembly and end-of-frame reporting.
module hdlc_rx_deframer (
    input  logic               Clk,
    input  logic               Rst,
    hdlc_rx_deframer_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        FRAME
    } state_t;

    state_t     state;
    logic [7:0] window;
    logic [6:0] shreg;
    logic [2:0] ones_cnt;
    logic [2:0] bit_cnt;
    logic [2:0] drop_cnt;
    logic       flag_hit;
    logic       abort_hit;
    logic       err_hit;
    logic       eof_pend;
    logic       asig_pend;
    logic       err_pend;

    logic flag_now;
    logic abort_now;
    logic out_bit;
    logic stuffed;

    assign flag_now  = (window == 8'h7E);
    assign abort_now = (window == 8'hFE);
    assign out_bit   = window[0];
    assign stuffed   = !out_bit && (ones_cnt == 3'd5);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state              <= IDLE;
            window             <= '1;
            shreg              <= '0;
            ones_cnt           <= '0;
            bit_cnt            <= '0;
            drop_cnt           <= '0;
            flag_hit           <= 1'b0;
            abort_hit          <= 1'b0;
            err_hit            <= 1'b0;
            eof_pend           <= 1'b0;
            asig_pend          <= 1'b0;
            err_pend           <= 1'b0;
            bus.Rx_FlagDetect  <= 1'b0;
            bus.Rx_AbortDetect <= 1'b0;
            bus.Rx_AbortSignal <= 1'b0;
            bus.Rx_ValidFrame  <= 1'b0;
            bus.Rx_Data        <= 8'h00;
            bus.Rx_WrBuff      <= 1'b0;
            bus.Rx_EoF         <= 1'b0;
            bus.Rx_FrameError  <= 1'b0;
        end else if (!bus.RxEN) begin
            state              <= IDLE;
            window             <= '1;
            ones_cnt           <= '0;
            bit_cnt            <= '0;
            drop_cnt           <= '0;
            flag_hit           <= 1'b0;
            abort_hit          <= 1'b0;
            err_hit            <= 1'b0;
            eof_pend           <= 1'b0;
            asig_pend          <= 1'b0;
            err_pend           <= 1'b0;
            bus.Rx_FlagDetect  <= 1'b0;
            bus.Rx_AbortDetect <= 1'b0;
            bus.Rx_AbortSignal <= 1'b0;
            bus.Rx_ValidFrame  <= 1'b0;
            bus.Rx_WrBuff      <= 1'b0;
            bus.Rx_EoF         <= 1'b0;
            bus.Rx_FrameError  <= 1'b0;
        end else begin
            window        <= {bus.Rx, window[7:1]};
            flag_hit      <= flag_now;
            abort_hit     <= abort_now;
            err_hit       <= flag_now && (bit_cnt != 3'd0);
            bus.Rx_WrBuff <= 1'b0;

            // The bit leaving the window is released; a flag
            // drops itself by skipping the next 8 released bits.
            unique case (state)
                IDLE: state <= HUNT;
                HUNT: begin
                    if (flag_now) begin
                        state    <= FRAME;
                        drop_cnt <= 3'd7;
                        bit_cnt  <= '0;
                        ones_cnt <= '0;
                    end
                end
                FRAME: begin
                    if (abort_now) begin
                        state    <= HUNT;
                        drop_cnt <= '0;
                        bit_cnt  <= '0;
                        ones_cnt <= '0;
                    end else if (flag_now) begin
                        drop_cnt <= 3'd7;
                        bit_cnt  <= '0;
                        ones_cnt <= '0;
                    end else if (drop_cnt != 3'd0) begin
                        drop_cnt <= drop_cnt - 3'd1;
                    end else if (stuffed) begin
                        ones_cnt <= '0;
                    end else begin
                        if (!out_bit)
                            ones_cnt <= '0;
                        else if (ones_cnt != 3'd7)
                            ones_cnt <= ones_cnt + 3'd1;
                        shreg   <= {out_bit, shreg[6:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            bus.Rx_Data       <= {out_bit, shreg};
                            bus.Rx_WrBuff     <= 1'b1;
                            bus.Rx_ValidFrame <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            bus.Rx_FlagDetect  <= flag_hit;
            bus.Rx_AbortDetect <= abort_hit;
            eof_pend  <= (flag_hit || abort_hit) && bus.Rx_ValidFrame;
            asig_pend <= abort_hit && bus.Rx_ValidFrame;
            err_pend  <= flag_hit && err_hit && bus.Rx_ValidFrame;
            if (flag_hit || abort_hit)
                bus.Rx_ValidFrame <= 1'b0;

            bus.Rx_EoF         <= eof_pend;
            bus.Rx_AbortSignal <= asig_pend;
            bus.Rx_FrameError  <= err_pend;
        end
    end
endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Scoreboard bench for hdlc_rx_deframer: directed bit streams,
// expected events queued by the driver and matched by a monitor.
module tb_hdlc_rx_deframer;
    localparam int K_VFF   = 0;
    localparam int K_FLAG  = 1;
    localparam int K_ABORT = 2;
    localparam int K_WR    = 3;
    localparam int K_VFR   = 4;
    localparam int K_ASIG  = 5;
    localparam int K_EOF   = 6;
    localparam int K_FERR  = 7;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         at;
    } ev_t;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_at = 0;
    logic vf_q = 1'b0;
    ev_t  sbq[$];

    hdlc_rx_deframer_if bus ();

    hdlc_rx_deframer dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_VFF:   return "valid_fall";
            K_FLAG:  return "flag_detect";
            K_ABORT: return "abort_detect";
            K_WR:    return "wrbuff";
            K_VFR:   return "valid_rise";
            K_ASIG:  return "abort_signal";
            K_EOF:   return "eof";
            K_FERR:  return "frame_error_alone";
            default: return "unknown";
        endcase
    endfunction

    task automatic push(input int k, input logic [7:0] d,
                        input int at);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.at   = at;
        sbq.push_back(e);
    endtask

    task automatic got(input int k, input logic [7:0] d);
        ev_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL %s: got event data %02h at edge %0d, required no event",
                     kname(k), d, cyc);
        end else begin
            e = sbq.pop_front();
            if (e.kind != k || e.data != d ||
                (e.at >= 0 && e.at != cyc)) begin
                errors++;
                $display("FAIL %s: got %s data %02h edge %0d, required %s data %02h edge %0d",
                         kname(e.kind), kname(k), d, cyc,
                         kname(e.kind), e.data, e.at);
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, required %02h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flag"}, {7'd0, bus.Rx_FlagDetect}, 8'h00);
        chk({tag, "_abort"}, {7'd0, bus.Rx_AbortDetect}, 8'h00);
        chk({tag, "_asig"}, {7'd0, bus.Rx_AbortSignal}, 8'h00);
        chk({tag, "_valid"}, {7'd0, bus.Rx_ValidFrame}, 8'h00);
        chk({tag, "_data"}, bus.Rx_Data, 8'h00);
        chk({tag, "_wrbuff"}, {7'd0, bus.Rx_WrBuff}, 8'h00);
        chk({tag, "_eof"}, {7'd0, bus.Rx_EoF}, 8'h00);
        chk({tag, "_ferr"}, {7'd0, bus.Rx_FrameError}, 8'h00);
    endtask

    task automatic chk_empty(input string tag);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events missing (next %s), required 0",
                     tag, sbq.size(), kname(sbq[0].kind));
            sbq.delete();
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge Clk);
        bus.Rx  = b;
        last_at = cyc + 1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic send_ones(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic start_test();
        @(negedge Clk);
        bus.RxEN = 1'b0;
        bus.Rx   = 1'b1;
        repeat (2) @(negedge Clk);
        bus.RxEN = 1'b1;
    endtask

    task automatic end_test(input string tag);
        send_ones(5);
        @(negedge Clk);
        bus.RxEN = 1'b0;
        repeat (12) @(negedge Clk);
        chk_empty(tag);
    endtask

    // Monitor: event order within one cycle is fixed here.
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (vf_q && !bus.Rx_ValidFrame) got(K_VFF, 8'h00);
            if (bus.Rx_FlagDetect) got(K_FLAG, 8'h00);
            if (bus.Rx_AbortDetect) got(K_ABORT, 8'h00);
            if (bus.Rx_WrBuff) got(K_WR, bus.Rx_Data);
            if (!vf_q && bus.Rx_ValidFrame) begin
                got(K_VFR, 8'h00);
                chk("valid_rise_with_wrbuff",
                    {7'd0, bus.Rx_WrBuff}, 8'h01);
            end
            if (bus.Rx_AbortSignal) got(K_ASIG, 8'h00);
            if (bus.Rx_EoF)
                got(K_EOF, {7'd0, bus.Rx_FrameError});
            else if (bus.Rx_FrameError)
                got(K_FERR, 8'h00);
            vf_q = bus.Rx_ValidFrame;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] stuffed_ff;
        stuffed_ff = 9'b111011111;
        bus.RxEN = 1'b0;
        bus.Rx   = 1'b1;
        Rst      = 1'b0;
        repeat (2) @(negedge Clk);
        bus.RxEN = 1'b1;
        repeat (2) @(negedge Clk);
        chk_zero("reset");
        @(negedge Clk);
        Rst = 1'b1;

        // Lone flag on idle line, then a run of ones in HUNT/empty frame
        start_test();
        send_ones(16);
        send_flag_exp();
        send_ones(7);
        push(K_ABORT, 8'h00, last_at + 2);
        send_ones(3);
        end_test("idle_flag");

        // Two-byte frame
        start_test();
        send_ones(4);
        send_flag_exp();
        send_byte(8'hA5);
        push(K_WR, 8'hA5, -1);
        push(K_VFR, 8'h00, -1);
        send_byte(8'h3C);
        push(K_WR, 8'h3C, -1);
        send_close(1'b0);
        end_test("two_bytes");

        // Stuffed 0xFF
        start_test();
        send_ones(4);
        send_flag_exp();
        for (int i = 0; i < 9; i++) send_bit(stuffed_ff[i]);
        push(K_WR, 8'hFF, -1);
        push(K_VFR, 8'h00, -1);
        send_close(1'b0);
        end_test("stuffed_ff");

        // Abort inside a frame, then FSM back in HUNT
        start_test();
        send_ones(4);
        send_flag_exp();
        send_byte(8'h12);
        push(K_WR, 8'h12, -1);
        push(K_VFR, 8'h00, -1);
        send_bit(1'b0);
        send_ones(7);
        push(K_VFF, 8'h00, last_at + 2);
        push(K_ABORT, 8'h00, last_at + 2);
        push(K_ASIG, 8'h00, last_at + 3);
        push(K_EOF, 8'h00, last_at + 3);
        send_ones(5);
        send_byte(8'h55);
        send_flag_exp();
        end_test("abort");

        // Non-octet-aligned frame
        start_test();
        send_ones(4);
        send_flag_exp();
        send_byte(8'h12);
        push(K_WR, 8'h12, -1);
        push(K_VFR, 8'h00, -1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_close(1'b1);
        end_test("frame_error");

        // Back-to-back flags
        start_test();
        send_ones(4);
        send_flag_exp();
        send_flag_exp();
        send_flag_exp();
        end_test("b2b_flags");

        // Asynchronous reset mid-frame
        start_test();
        send_ones(4);
        send_flag_exp();
        send_byte(8'hA5);
        push(K_WR, 8'hA5, -1);
        push(K_VFR, 8'h00, -1);
        send_byte(8'h00);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        push(K_VFF, 8'h00, -1);
        #2;
        Rst = 1'b0;
        #1;
        chk_zero("mid_reset");
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        send_ones(20);
        end_test("reset_release");

        // RxEN dropped mid-frame
        start_test();
        send_ones(4);
        send_flag_exp();
        send_byte(8'h3C);
        push(K_WR, 8'h3C, -1);
        push(K_VFR, 8'h00, -1);
        send_byte(8'h00);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge Clk);
        bus.RxEN = 1'b0;
        push(K_VFF, 8'h00, cyc + 1);
        repeat (12) @(negedge Clk);
        chk_empty("rxen_drop");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    task automatic send_flag_exp();
        send_byte(8'h7E);
        push(K_FLAG, 8'h00, last_at + 2);
    endtask

    task automatic send_close(input logic ferr);
        send_byte(8'h7E);
        push(K_VFF, 8'h00, last_at + 2);
        push(K_FLAG, 8'h00, last_at + 2);
        push(K_EOF, {7'd0, ferr}, last_at + 3);
    endtask
endmodule
